// File: rtl/scan_decoder.sv
// One-hot decoder with registered outputs: direct-load or prescaled auto-scan.
// Optional SCAN_BLANK_EN: blank D on the last cycle of each scan step.
module scan_decoder #(
  parameter int N        = 3,
  parameter int OUTS     = 8,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            E,
  input  logic            MODE,
  input  logic            LD,
  input  logic [N-1:0]    A,
  output logic [OUTS-1:0] D,
  output logic [N-1:0]    IDX,
  output logic            WRAP,
  output logic            ERR
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LASTC  = CW'(PRESCALE - 1);
  localparam logic [N-1:0]  LASTI  = N'(OUTS - 1);
  localparam logic [N:0]    OUTS_W = (N + 1)'(OUTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [OUTS-1:0] d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;
  logic            a_ok;

  function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
    logic [OUTS-1:0] oh;
    for (int k = 0; k < OUTS; k++) begin
      oh[k] = (int'(i) == k);
    end
    return oh;
  endfunction

  assign a_ok = ({1'b0, A} < OUTS_W);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (!E) begin
      state_d = S_IDLE;
      d_d     = '0;
      cnt_d   = '0;
    end else if (!MODE) begin
      state_d = S_DIRECT;
      cnt_d   = '0;
      if (LD) begin
        if (a_ok) idx_d = A;
        else      err_d = 1'b1;
      end
      d_d = onehot(idx_d);
    end else begin
      state_d = S_SCAN;
      // Entering scan restarts the prescaler; a step never coincides with entry.
      if (state_q != S_SCAN) begin
        cnt_d = '0;
      end else if (cnt_q == LASTC) begin
        cnt_d = '0;
        if (idx_q == LASTI) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + N'(1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      d_d = onehot(idx_d);
`ifdef SCAN_BLANK_EN
      if (cnt_d == LASTC) d_d = '0;
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign D    = d_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised N-to-OUTS one-hot decoder with registered outputs.
- Two modes: direct-load, where the latched address is decoded, and auto-scan, where an internal index sweeps 0..OUTS-1 at a prescaled rate.
- Drives multiplexed digit/row selects, e.g. 7-segment digit strobes, and replaces hand-cascaded fixed-size decoders in datapath labs.

Parameters:
- N, 3, select/index width in bits (N >= 1).
- OUTS, 8, number of decoded outputs (2 <= OUTS <= 2**N).
- PRESCALE, 4, clock cycles per scan step (PRESCALE >= 1; >= 2 when SCAN_BLANK_EN is defined).

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- E, input, 1, enable; 0 blanks all outputs.
- MODE, input, 1, 0 = direct, 1 = scan.
- LD, input, 1, direct-mode load strobe; sampled when E=1 and MODE=0.
- A, input, N, direct-mode address.
- D, output, OUTS, registered one-hot decode (active-high).
- IDX, output, N, registered current index.
- WRAP, output, 1, one-cycle pulse when the scan index wraps to 0.
- ERR, output, 1, one-cycle pulse when LD is given with A >= OUTS.

Behaviour:
- Reset:
  - Applied when rst=1 at a clock edge; sets D=0, IDX=0, WRAP=0, ERR=0, prescale count=0, state=IDLE.
  - rst has priority over every other input, including mid-scan and mid-load.
- States are IDLE, DIRECT and SCAN. Each edge, with rst=0:
  - E=0: go to IDLE. D=0 next cycle, IDX holds, prescale count cleared, WRAP=ERR=0.
  - E=1, MODE=0: go to DIRECT.
  - E=1, MODE=1: go to SCAN.
- IDLE->DIRECT or IDLE->SCAN: D=onehot(IDX) on the cycle after entry. IDX is preserved from before the disable.
- DIRECT:
  - LD=1 and A < OUTS: IDX<=A and D<=onehot(A). Latency is 1 cycle from the LD edge.
  - LD=1 and A >= OUTS: IDX and D unchanged; ERR=1 for exactly one cycle.
  - LD=0: hold.
  - Back-to-back LD every cycle is legal; each load is visible one cycle later.
- SCAN:
  - The prescale counter counts 0..PRESCALE-1.
  - On the edge where the count equals PRESCALE-1: count<=0 and IDX<=IDX+1, or IDX<=0 if IDX==OUTS-1.
  - D always equals onehot(IDX) with the same registered timing as IDX.
  - WRAP=1 on the same cycle IDX becomes 0 through a wrap. WRAP does not fire on entry to SCAN at IDX=0.
  - PRESCALE=1: IDX advances every cycle.
  - LD is ignored in SCAN; ERR is never asserted in SCAN.
- Mode switches:
  - DIRECT->SCAN: scanning starts from the current IDX with the prescale count cleared. The first step occurs PRESCALE cycles after the switch edge.
  - SCAN->DIRECT: IDX and D freeze at the current value until the next valid LD.
  - A switch on the same edge as the terminal prescale count: the mode change wins and no step occurs.
- Invariants:
  - D is either all-zero or exactly one-hot; it is never multi-hot.
  - Bits of D at index >= OUTS do not exist.
  - IDX is never >= OUTS.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: in SCAN, D=0 during the last cycle of each step (prescale count == PRESCALE-1), for anti-ghosting. IDX and WRAP timing are unchanged. The step period stays PRESCALE cycles, of which PRESCALE-1 are lit. DIRECT mode is unaffected.
- Undefined: D is lit for every cycle of the step, as described above.

Test Plan (N=3, OUTS=6, PRESCALE=4):
- Reset and load:
  - Stimulus: rst=1 for 2 cycles, then E=1, MODE=0, LD pulse with A=5.
  - Required: D=0 and IDX=0 during reset; D=6'b100000 and IDX=5 one cycle after the LD.
- Out-of-range load:
  - Stimulus: DIRECT holding IDX=2, then LD with A=7.
  - Required: ERR=1 for one cycle; D stays 6'b000100 and IDX stays 2.
- Scan sweep:
  - Stimulus: MODE=1 from IDX=4.
  - Required: IDX sequence 4,5,0,1,..., each value held 4 cycles; WRAP=1 for exactly one cycle on the 5->0 transition; D always one-hot matching IDX.
- Disable and resume:
  - Stimulus: E=0 mid-scan at IDX=3 for 5 cycles, then E=1.
  - Required: D=0 the cycle after E falls; IDX holds 3; after re-enable D=6'b001000 and the next step comes 4 cycles later.
- Reset mid-scan and mode switch:
  - Stimulus: rst=1 during SCAN at IDX=5, then release with MODE=0.
  - Required: IDX=0, D=0, WRAP=0 during reset; after release, DIRECT shows D=6'b000001 and no WRAP.
- Blanking (SCAN_BLANK_EN defined):
  - Stimulus: scan from IDX=0.
  - Required: per step, D one-hot for 3 cycles then 0 for 1 cycle; the IDX sequence is identical to the undefined build.
